// File: rtl/serial_rx.sv
`default_nettype none
//============================================================================
// Module   : serial_rx
// Purpose  : Asynchronous serial frame receiver (1 start bit, DATA_W data
//            bits LSB first, 1 stop bit) with a one-entry output register,
//            valid/ready handshake, framing-error and overrun pulses.
// Revision : 1.0 - initial release
//============================================================================
module serial_rx #(
    parameter int CLKS_PER_BIT = 4,     // even and >= 4
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,    // asynchronous, active low
    input  logic              d,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              overrun
);

    // Counter spans 0..CLKS_PER_BIT-1; bit index spans 0..DATA_W-1.
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] c_BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    // Synchronizer stages; r_ds is the only view of the line used below.
    logic              r_sync1;
    logic              r_ds;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [BW-1:0]     r_bidx;
    logic [BW-1:0]     w_bidx_nxt;
    logic [DATA_W-1:0] r_shift;

    logic              w_shift_en;   // sample r_ds into r_shift[r_bidx]
    logic              w_good;       // stop bit sampled high
    logic              w_bad;        // stop bit sampled low

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_overrun;

    // Two-flop synchronizer, idle-high reset so release does not look like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_ds    <= 1'b1;
        end else begin
            r_sync1 <= d;
            r_ds    <= r_sync1;
        end
    end

    // FSM state, cycle counter and bit index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bidx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bidx  <= w_bidx_nxt;
        end
    end

    // Next-state logic; the counter is cleared on every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bidx_nxt  = r_bidx;
        w_shift_en  = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_ds) begin
                    w_state_nxt = S_START;
                end
            end

            // Re-check the line half a bit in: a high level means a glitch.
            S_START: begin
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_nxt = '0;
                    if (r_ds) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_bidx_nxt  = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            // One sample per bit period, roughly mid-bit thanks to the half-bit start offset.
            S_DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt  = '0;
                    w_shift_en = 1'b1;
                    if (r_bidx == c_BIT_LAST) begin
                        w_state_nxt = S_STOP;
                        w_bidx_nxt  = '0;
                    end else begin
                        w_bidx_nxt = r_bidx + BW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            S_STOP: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_ds) begin
                        w_good      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bad       = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            // A broken frame leaves the line low; wait for it to go idle
            // so the low level is not mistaken for a new start bit.
            S_WAIT_IDLE: begin
                w_cnt_nxt = '0;
                if (r_ds) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bidx_nxt  = '0;
            end
        endcase
    end

    // Data shift register, filled LSB first at the current bit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift[r_bidx] <= r_ds;
        end
    end

    // Output register with handshake: a completed frame may replace a byte
    // that is being consumed on the same edge, otherwise it is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            r_overrun   <= w_good && r_valid && !ready;
            if (w_good && (!r_valid || ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
//============================================================================
// Module   : tb_serial_rx
// Purpose  : Directed self-checking bench for serial_rx (default parameters).
// Revision : 1.0 - initial release
//============================================================================
module tb_serial_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       d;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    // Event monitor state, cleared at the start of each scenario
    int         vr_cnt;     // valid rising edges
    int         vr_cyc;     // cycle of last valid rise
    logic [7:0] vdata;      // data captured at valid rise
    int         vhigh;      // cycles valid observed high
    int         fe_cnt;     // cycles frame_err observed high
    int         fe_cyc;
    int         ov_cnt;     // cycles overrun observed high
    int         ov_cyc;
    logic       prev_valid;

    serial_rx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .ready     (ready),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            vr_cnt = vr_cnt + 1;
            vr_cyc = cyc;
            vdata  = data;
        end
        if (valid)     vhigh  = vhigh + 1;
        if (frame_err) begin fe_cnt = fe_cnt + 1; fe_cyc = cyc; end
        if (overrun)   begin ov_cnt = ov_cnt + 1; ov_cyc = cyc; end
        prev_valid = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clears the monitor away from its active edge, returns on a negedge.
    task automatic clr_mon();
        @(posedge clk);
        vr_cnt = 0; vr_cyc = 0; vdata = 8'h00; vhigh = 0;
        fe_cnt = 0; fe_cyc = 0; ov_cnt = 0; ov_cyc = 0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        d = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting on the current negedge; t0 is the posedge
    // at which the start bit is first sampled. Returns on the negedge just
    // before the frame's completion edge (t0 + 40).
    task automatic send_frame(input logic [7:0] b, input logic stopb);
        logic [9:0] f;
        f  = {stopb, b, 1'b0};
        t0 = cyc + 1;
        for (int i = 0; i < 10 * CPB; i++) begin
            d = f[i / CPB];
            @(negedge clk);
        end
    endtask

    int t0a;

    initial begin
        prev_valid = 1'b0;
        vr_cnt = 0; vr_cyc = 0; vdata = 8'h00; vhigh = 0;
        fe_cnt = 0; fe_cyc = 0; ov_cnt = 0; ov_cyc = 0;
        reset = 1'b0;
        d     = 1'b1;
        ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_data",  {24'd0, data}, 32'h00);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ferr",  {31'd0, frame_err}, 32'd0);
        check("rst_ovr",   {31'd0, overrun}, 32'd0);
        reset = 1'b1;
        idle(4);

        // Good frame 0xA5, ready high
        ready = 1'b1;
        clr_mon();
        send_frame(8'hA5, 1'b1);
        idle(6);
        check("a5_vrise",   vr_cnt, 32'd1);
        check("a5_latency", vr_cyc - t0, 32'd40);
        check("a5_data",    {24'd0, vdata}, 32'hA5);
        check("a5_vwidth",  vhigh, 32'd1);
        check("a5_ferr",    fe_cnt, 32'd0);
        check("a5_ovr",     ov_cnt, 32'd0);

        // One-cycle glitch on the line
        clr_mon();
        d = 1'b0;
        @(negedge clk);
        idle(20);
        check("gl_vrise", vr_cnt, 32'd0);
        check("gl_ferr",  fe_cnt, 32'd0);
        check("gl_ovr",   ov_cnt, 32'd0);
        check("gl_valid", {31'd0, valid}, 32'd0);

        // Framing error on 0x3C, line held low, then good frame 0x11
        clr_mon();
        send_frame(8'h3C, 1'b0);
        t0a = t0;
        d = 1'b0;
        repeat (8) @(negedge clk);
        idle(8);
        check("fe_count", fe_cnt, 32'd1);
        check("fe_cycle", fe_cyc - t0a, 32'd40);
        check("fe_vrise", vr_cnt, 32'd0);
        send_frame(8'h11, 1'b1);
        idle(6);
        check("fe_next_vrise", vr_cnt, 32'd1);
        check("fe_next_data",  {24'd0, vdata}, 32'h11);
        check("fe_next_lat",   vr_cyc - t0, 32'd40);
        check("fe_total",      fe_cnt, 32'd1);
        check("fe_ovr",        ov_cnt, 32'd0);

        // Back-to-back 0x01, 0x02 with ready low: overrun on the second
        ready = 1'b0;
        clr_mon();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        idle(4);
        check("ov_count", ov_cnt, 32'd1);
        check("ov_cycle", ov_cyc - t0, 32'd40);
        check("ov_vrise", vr_cnt, 32'd1);
        check("ov_data",  {24'd0, data}, 32'h01);
        check("ov_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        @(negedge clk);
        check("ov_cleared", {31'd0, valid}, 32'd0);
        ready = 1'b0;
        idle(2);

        // Back-to-back 0x01, 0x02 with ready pulsed on the completion edge
        clr_mon();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("rp_valid", {31'd0, valid}, 32'd1);
        check("rp_data",  {24'd0, data}, 32'h02);
        check("rp_ovr",   ov_cnt, 32'd0);
        check("rp_vrise", vr_cnt, 32'd1);
        idle(2);

        // Reset during data bit 4 of 0xFF, valid still pending from above
        clr_mon();
        d = 1'b0;
        repeat (CPB) @(negedge clk);
        d = 1'b1;
        repeat (18) @(negedge clk);
        reset = 1'b0;
        #1;
        check("ar_valid", {31'd0, valid}, 32'd0);
        check("ar_data",  {24'd0, data}, 32'h00);
        repeat (3) @(negedge clk);
        check("ar_hold_valid", {31'd0, valid}, 32'd0);
        check("ar_hold_ferr",  {31'd0, frame_err}, 32'd0);
        check("ar_hold_ovr",   {31'd0, overrun}, 32'd0);
        reset = 1'b1;
        ready = 1'b1;
        idle(40);
        check("ar_no_vrise", vr_cnt, 32'd0);
        check("ar_no_ferr",  fe_cnt, 32'd0);
        check("ar_no_ovr",   ov_cnt, 32'd0);
        clr_mon();
        send_frame(8'h5A, 1'b1);
        idle(6);
        check("ar_5a_vrise", vr_cnt, 32'd1);
        check("ar_5a_data",  {24'd0, vdata}, 32'h5A);
        check("ar_5a_lat",   vr_cyc - t0, 32'd40);
        check("ar_5a_ferr",  fe_cnt, 32'd0);
        check("ar_5a_ovr",   ov_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
